// File: rtl/reg_dump_tx.sv
// reg_dump_tx: on a CPU halt (or an explicit request) snapshots the seven
// exposed 16-bit registers and sends them as one 15-byte UART 8N1 frame
// (sync byte, then each register high byte first). After a halt-triggered
// dump it can pulse unhalt so the CPU resumes.
module reg_dump_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          AUTO_UNHALT  = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         halted,
  input  logic [111:0] regexpose,
  input  logic         dump_req,
  output logic         tx,
  output logic         busy,
  output logic         unhalt
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        LAST_BYTE = 4'd14;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud;
  logic [2:0]          bit_idx;
  logic [3:0]          byte_idx;
  logic                halted_q;
  logic                from_halt;
  logic [111:0]        shadow;
  logic [127:0]        frame;
  logic [7:0]          cur_byte;
  logic                halt_trig;
  logic                trigger;
  logic                bit_end;

  assign halt_trig = halted & ~halted_q;
  assign trigger   = halt_trig | dump_req;
  assign bit_end   = (baud == BAUD_LAST);

  // Lay the snapshot out as the byte sequence on the wire; byte k sits at frame[8k +: 8].
  // The unused top byte keeps the indexed select in range for every byte_idx value.
  always_comb begin
    frame          = '0;
    frame[7:0]     = SYNC_BYTE;
    for (int i = 0; i < 7; i++) begin
      frame[16*i + 8  +: 8] = shadow[16*i + 8 +: 8];
      frame[16*i + 16 +: 8] = shadow[16*i     +: 8];
    end
    frame[127:120] = 8'hFF;
    cur_byte       = frame[{byte_idx, 3'b000} +: 8];
  end

  // Register snapshot: taken in the cycle a frame starts, held for the whole frame.
  always_ff @(posedge clk) begin
    if (state == IDLE && trigger) begin
      shadow <= regexpose;
    end
  end

  // Frame sequencer: bit timing, byte stepping and the registered tx/busy/unhalt outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      unhalt    <= 1'b0;
      baud      <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      halted_q  <= 1'b0;
      from_halt <= 1'b0;
    end else begin
      halted_q <= halted;
      unhalt   <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (trigger) begin
            from_halt <= halt_trig;
            state     <= START;
            tx        <= 1'b0;
            busy      <= 1'b1;
            baud      <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= cur_byte[0];
            state   <= DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (byte_idx == LAST_BYTE) begin
              state  <= DONE;
              busy   <= 1'b0;
              tx     <= 1'b1;
              // Only resume a CPU that halted this dump and is still halted.
              unhalt <= (AUTO_UNHALT != 0) && from_halt && halted;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              bit_idx  <= '0;
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        DONE: begin
          tx       <= 1'b1;
          byte_idx <= '0;
          state    <= IDLE;
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: UART monitor decodes tx into a received-byte queue,
// each scenario pushes the bytes it expects and compares after the frame.
module tb_reg_dump_tx;

  localparam int         CPB  = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         halted = 1'b0;
  logic         dump_req = 1'b0;
  logic [111:0] regexpose = '0;
  logic         tx, busy, unhalt;
  logic         tx0, busy0, unhalt0;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  logic       mon_act = 1'b0;
  int         mon_off = 0;
  logic [7:0] mon_sh = 8'h00;
  int         frame_err = 0;
  int         u0_cnt = 0;

  reg_dump_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC), .AUTO_UNHALT(1)) u_dut (
    .clk(clk), .rst(rst), .halted(halted), .regexpose(regexpose),
    .dump_req(dump_req), .tx(tx), .busy(busy), .unhalt(unhalt)
  );

  reg_dump_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC), .AUTO_UNHALT(0)) u_dut_nu (
    .clk(clk), .rst(rst), .halted(halted), .regexpose(regexpose),
    .dump_req(dump_req), .tx(tx0), .busy(busy0), .unhalt(unhalt0)
  );

  always #5 clk = ~clk;

  // UART receiver: finds a start bit, samples each bit mid-cell, pushes decoded bytes.
  always @(negedge clk) begin
    if (rst) begin
      mon_act <= 1'b0;
    end else if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act <= 1'b1;
        mon_off <= 1;
      end
    end else begin
      mon_off <= mon_off + 1;
      if (mon_off >= CPB && mon_off < 9 * CPB && (mon_off % CPB) == CPB / 2)
        mon_sh[mon_off / CPB - 1] <= tx;
      if (mon_off == 9 * CPB + CPB / 2) begin
        rx_q.push_back(mon_sh);
        if (tx !== 1'b1) frame_err <= frame_err + 1;
        mon_act <= 1'b0;
      end
    end
  end

  // Count unhalt pulses from the instance built without auto-unhalt.
  always @(posedge clk) begin
    if (unhalt0 === 1'b1) u0_cnt <= u0_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic [111:0] r);
    exp_q.push_back(SYNC);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(r[16*i + 8 +: 8]);
      exp_q.push_back(r[16*i +: 8]);
    end
  endtask

  // Runs n cycles after the start edge, collecting unhalt pulses and tx divergence.
  task automatic watch(input int n, output int pulses, output int first_at,
                       output logic busy_at, output int txdiff);
    pulses = 0; first_at = -1; busy_at = 1'b1; txdiff = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (unhalt === 1'b1) begin
        pulses++;
        if (first_at < 0) begin
          first_at = k;
          busy_at  = busy;
        end
      end
      if (tx !== tx0) txdiff++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || unhalt !== 1'b0) begin
      errors++;
      $display("FAIL reset_state tx=%b busy=%b unhalt=%b required 1 0 0", tx, busy, unhalt);
    end
    rst = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1 || busy !== 1'b0 || unhalt !== 1'b0 || unhalt0 !== 1'b0) begin
        errors++;
        $display("FAIL idle cycle %0d tx=%b busy=%b unhalt=%b required 1 0 0", k, tx, busy, unhalt);
      end
    end
  endtask

  task automatic test_halt_dump();
    int p, at, d;
    logic b;
    logic [7:0] e, a;
    regexpose = {16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001, 16'h0000};
    push_frame(regexpose);
    halted = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      errors++;
      $display("FAIL halt_start busy=%b tx=%b required 1 0", busy, tx);
    end
    watch(610, p, at, b, d);
    checks++;
    if (p !== 1 || at !== 600) begin
      errors++;
      $display("FAIL halt_unhalt pulses=%0d at=%0d required 1 at 600", p, at);
    end
    checks++;
    if (b !== 1'b0) begin
      errors++;
      $display("FAIL halt_busy_at_unhalt busy=%b required 0", b);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL halt_byte_count got %0d required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && rx_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = rx_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL halt_byte %0d got %h required %h", i, a, e);
      end
    end
    exp_q.delete(); rx_q.delete();
    halted = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_dump_req();
    int p, at, d;
    logic b;
    logic [7:0] e, a;
    regexpose = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    regexpose[63:48] = 16'hBEEF;
    push_frame(regexpose);
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL req_start busy=%b required 1", busy);
    end
    watch(610, p, at, b, d);
    checks++;
    if (p !== 0) begin
      errors++;
      $display("FAIL req_unhalt pulses=%0d required 0", p);
    end
    checks++;
    if (rx_q.size() >= 9) begin
      if (rx_q[7] !== 8'hBE || rx_q[8] !== 8'hEF) begin
        errors++;
        $display("FAIL req_r3_bytes got %h %h required be ef", rx_q[7], rx_q[8]);
      end
    end else begin
      errors++;
      $display("FAIL req_r3_bytes only %0d bytes received required 15", rx_q.size());
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL req_byte_count got %0d required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && rx_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = rx_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL req_byte %0d got %h required %h", i, a, e);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_snapshot();
    logic [7:0] e, a;
    int busy_rises;
    logic busy_prev;
    regexpose = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    push_frame(regexpose);
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    busy_rises = 1;
    busy_prev  = busy;
    for (int k = 1; k <= 700; k++) begin
      @(posedge clk); #1;
      if (busy === 1'b1 && busy_prev !== 1'b1) busy_rises++;
      busy_prev = busy;
      if (k == 100) regexpose = '1;
      if (k == 200) dump_req = 1'b1;
      if (k == 201) dump_req = 1'b0;
    end
    checks++;
    if (busy_rises !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL snap_frames busy_rises=%0d busy=%b required 1 0", busy_rises, busy);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL snap_byte_count got %0d required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && rx_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = rx_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL snap_byte %0d got %h required %h", i, a, e);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_reset_abort();
    int p, at, d;
    logic b;
    logic [7:0] e, a;
    regexpose = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    halted = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k < 300; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    halted = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || unhalt !== 1'b0) begin
      errors++;
      $display("FAIL abort_state tx=%b busy=%b unhalt=%b required 1 0 0", tx, busy, unhalt);
    end
    p = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (unhalt === 1'b1 || busy !== 1'b0 || tx !== 1'b1) p++;
    end
    checks++;
    if (p !== 0) begin
      errors++;
      $display("FAIL abort_quiet active_cycles=%0d required 0", p);
    end
    exp_q.delete(); rx_q.delete();
    regexpose = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    push_frame(regexpose);
    halted = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rehalt_start busy=%b required 1", busy);
    end
    watch(610, p, at, b, d);
    checks++;
    if (p !== 1 || at !== 600) begin
      errors++;
      $display("FAIL rehalt_unhalt pulses=%0d at=%0d required 1 at 600", p, at);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rehalt_byte_count got %0d required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && rx_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = rx_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL rehalt_byte %0d got %h required %h", i, a, e);
      end
    end
    exp_q.delete(); rx_q.delete();
    halted = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_same_cycle();
    int p, at, d, u0_before;
    logic b;
    logic [7:0] e, a;
    u0_before = u0_cnt;
    regexpose = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    push_frame(regexpose);
    halted   = 1'b1;
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
    checks++;
    if (busy !== 1'b1 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL both_start busy=%b busy_nu=%b required 1 1", busy, busy0);
    end
    watch(650, p, at, b, d);
    checks++;
    if (p !== 1 || at !== 600) begin
      errors++;
      $display("FAIL both_unhalt pulses=%0d at=%0d required 1 at 600", p, at);
    end
    checks++;
    if (d !== 0) begin
      errors++;
      $display("FAIL both_tx_no_auto differing_cycles=%0d required 0", d);
    end
    checks++;
    if (u0_cnt !== u0_before) begin
      errors++;
      $display("FAIL both_no_auto_unhalt pulses=%0d required 0", u0_cnt - u0_before);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL both_byte_count got %0d required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; exp_q.size() > 0 && rx_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = rx_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL both_byte %0d got %h required %h", i, a, e);
      end
    end
    exp_q.delete(); rx_q.delete();
    halted = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_halt_dump();
    test_dump_req();
    test_snapshot();
    test_reset_abort();
    test_same_cycle();
    checks++;
    if (frame_err !== 0) begin
      errors++;
      $display("FAIL stop_bits bad_stop_count=%0d required 0", frame_err);
    end
    checks++;
    if (u0_cnt !== 0) begin
      errors++;
      $display("FAIL no_auto_unhalt_total pulses=%0d required 0", u0_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
